cryptoveril: RTL and testbench
==============================

CRYPTOVERIL -- requirements
Module: cryptoveril

Interface
REQ-001 clk1  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk1).
REQ-003 input_data  input  16  plaintext word, sampled when ld=1.
REQ-004 key_bits  input  5  key, sampled when ld=1.
REQ-005 ld  input  1  load strobe; captures input_data and key_bits.
REQ-006 start  input  1  level-sensitive run enable.
REQ-007 output_data  output  16  registered ciphertext.
REQ-008 Internal observable registers: stg1_out[15:0], stg2_out[16:0], stg3_out[15:0], stg1_done, stg2_done.

Function
REQ-009 FSM states: IDLE, LOADED, S1, S2, S3, DONE.
REQ-010 ld=1 in any state: data_reg<=input_data, key_reg<=key_bits, stg1_done/stg2_done<=0, next state LOADED; ld has priority over start.
REQ-011 LOADED with start=1 -> S1; start=0 -> hold LOADED; IDLE ignores start.
REQ-012 S1 edge: stg1_out<=rotate-left(data_reg, key_reg[3:0]); stg1_done<=1; -> S2.
REQ-013 K16 = {key_reg[0], key_reg, key_reg, key_reg} (16 bits).
REQ-014 S2 edge: stg2_out<={1'b0,stg1_out}+{1'b0,K16} (17-bit, carry kept in bit 16); stg2_done<=1; -> S3.
REQ-015 S3 edge: stg3_out<=(stg2_out[15:0]+stg2_out[16]) mod 2^16 XOR {K16[7:0],K16[15:8]}; output_data<=same value; -> DONE.
REQ-016 Latency: output_data valid 4 rising edges after the edge that enters LOADED with start held high (LOADED->S1->S2->S3->DONE).
REQ-017 start deassert in S1/S2/S3 does not stall; pipeline completes.
REQ-018 DONE holds all registers regardless of start; new operation only via ld.
REQ-019 output_data holds previous result until S3 of the next operation overwrites it.
REQ-020 ld during S1-S3 aborts the current operation; output_data unchanged.

Reset
REQ-021 rst=0 at rising clk1: state<=IDLE; output_data, stg1_out, stg2_out, stg3_out, data_reg, key_reg <=0; stg1_done, stg2_done <=0.
REQ-022 Reset has priority over ld and start, including mid-operation.

Configuration
REQ-023 Macro CRYPTOVERIL_PARITY_EN defined: extra output out_parity (1 bit) = XOR-reduction of output_data, registered with it, reset 0.
REQ-024 Macro undefined: no out_parity port; all other behaviour identical.

Verification
REQ-025 input_data=16'hE1E1, key_bits=5'b11010, ld pulse then start=1 -> stg1_out=16'h8787, stg2_out=17'h0F2E1, output_data=16'hA88A; out_parity=0 if enabled.
REQ-026 input_data=16'hFFFF, key_bits=5'h1F -> stg1_out=16'hFFFF, stg2_out=17'h1FFFE, output_data=16'h0000.
REQ-027 input_data=16'h1234, key_bits=5'h00 -> output_data=16'h1234 (identity key).
REQ-028 rst=0 asserted during S2 -> next edge all outputs/flags 0, state IDLE; start alone never produces a result.
REQ-029 ld held low, start held high after DONE for 20 cycles -> output_data stable; second ld with new data -> new result 4 edges later.
REQ-030 ld and start both high in LOADED -> stays LOADED (reload) until ld drops.

Source files
------------

// File: rtl/cryptoveril.sv
// cryptoveril: 3-stage rotate/add/fold cipher on a 16-bit word
// with a 5-bit key, sequenced by a load/start FSM.
//
// Ports:
//   clk1        clock, all state on rising edge
//   rst         synchronous reset, active low
//   input_data  plaintext, captured when ld=1
//   key_bits    key, captured when ld=1
//   ld          load strobe, restarts from any state
//   start       level run enable, only honoured in LOADED
//   output_data registered ciphertext, updated in S3
//   stg1_out    rotate stage result
//   stg2_out    add stage result, carry in bit 16
//   stg3_out    fold stage result (same as output_data)
//   stg1_done   rotate stage completed
//   stg2_done   add stage completed
//   out_parity  XOR of output_data, only with
//               CRYPTOVERIL_PARITY_EN defined
module cryptoveril (
  input  logic        clk1,
  input  logic        rst,
  input  logic [15:0] input_data,
  input  logic [4:0]  key_bits,
  input  logic        ld,
  input  logic        start,
  output logic [15:0] output_data,
  output logic [15:0] stg1_out,
  output logic [16:0] stg2_out,
  output logic [15:0] stg3_out,
  output logic        stg1_done,
  output logic        stg2_done
`ifdef CRYPTOVERIL_PARITY_EN
  ,
  output logic        out_parity
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LOADED,
    S1,
    S2,
    S3,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] data_reg;
  logic [4:0]  key_reg;

  logic [15:0] k16;
  logic [4:0]  rinv;
  logic [15:0] rot_val;
  logic [16:0] add_val;
  logic [15:0] fold_val;
  logic [15:0] s3_val;

  // Key replicated to 16 bits, top bit padded with key LSB
  assign k16 = {key_reg[0], key_reg, key_reg, key_reg};

  // Rotate by 0 makes the right shift 16, which yields zero
  assign rinv    = 5'd16 - {1'b0, key_reg[3:0]};
  assign rot_val = (data_reg << key_reg[3:0])
                 | (data_reg >> rinv);

  assign add_val = {1'b0, stg1_out} + {1'b0, k16};

  // End-around carry, then XOR with byte-swapped key
  assign fold_val = stg2_out[15:0]
                  + {15'b0, stg2_out[16]};
  assign s3_val   = fold_val ^ {k16[7:0], k16[15:8]};

  always_ff @(posedge clk1) begin
    if (!rst) begin
      state       <= IDLE;
      data_reg    <= '0;
      key_reg     <= '0;
      output_data <= '0;
      stg1_out    <= '0;
      stg2_out    <= '0;
      stg3_out    <= '0;
      stg1_done   <= 1'b0;
      stg2_done   <= 1'b0;
`ifdef CRYPTOVERIL_PARITY_EN
      out_parity  <= 1'b0;
`endif
    end else if (ld) begin
      data_reg  <= input_data;
      key_reg   <= key_bits;
      stg1_done <= 1'b0;
      stg2_done <= 1'b0;
      state     <= LOADED;
    end else begin
      case (state)
        LOADED: begin
          if (start) state <= S1;
        end
        S1: begin
          stg1_out  <= rot_val;
          stg1_done <= 1'b1;
          state     <= S2;
        end
        S2: begin
          stg2_out  <= add_val;
          stg2_done <= 1'b1;
          state     <= S3;
        end
        S3: begin
          stg3_out    <= s3_val;
          output_data <= s3_val;
`ifdef CRYPTOVERIL_PARITY_EN
          out_parity  <= ^s3_val;
`endif
          state       <= DONE;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_cryptoveril.sv
// tb_cryptoveril: directed + random bench for cryptoveril,
// checked each cycle against a transaction-level model.
module tb_cryptoveril;

  logic        clk1;
  logic        rst;
  logic [15:0] input_data;
  logic [4:0]  key_bits;
  logic        ld;
  logic        start;
  logic [15:0] output_data;
  logic [15:0] stg1_out;
  logic [16:0] stg2_out;
  logic [15:0] stg3_out;
  logic        stg1_done;
  logic        stg2_done;
`ifdef CRYPTOVERIL_PARITY_EN
  logic        out_parity;
`endif

  cryptoveril dut (
    .clk1        (clk1),
    .rst         (rst),
    .input_data  (input_data),
    .key_bits    (key_bits),
    .ld          (ld),
    .start       (start),
    .output_data (output_data),
    .stg1_out    (stg1_out),
    .stg2_out    (stg2_out),
    .stg3_out    (stg3_out),
    .stg1_done   (stg1_done),
    .stg2_done   (stg2_done)
`ifdef CRYPTOVERIL_PARITY_EN
    ,
    .out_parity  (out_parity)
`endif
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [15:0] kexp(input logic [4:0] key);
    int k;
    k = int'(key);
    return 16'(((k & 1) << 15) | (k << 10) | (k << 5) | k);
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] d,
                                       input logic [4:0] key);
    int v, r;
    v = int'(d);
    r = int'(key) % 16;
    return 16'(((v << r) | (v >> (16 - r))) & 'hFFFF);
  endfunction

  function automatic logic [16:0] addk(input logic [15:0] s1,
                                       input logic [4:0] key);
    return 17'(int'(s1) + int'(kexp(key)));
  endfunction

  function automatic logic [15:0] fold(input logic [16:0] s2,
                                       input logic [4:0] key);
    int t, k, sw;
    t  = (int'(s2) % 65536 + int'(s2) / 65536) % 65536;
    k  = int'(kexp(key));
    sw = ((k % 256) * 256) + (k / 256);
    return 16'(t ^ sw);
  endfunction

  // Model: op progress -1 none, 0 loaded, 1..3 stage pending,
  // 4 finished
  int          prog;
  logic [15:0] m_data;
  logic [4:0]  m_key;
  logic [15:0] m_s1;
  logic [16:0] m_s2;
  logic [15:0] m_out;
  logic        m_s1d;
  logic        m_s2d;

  always @(posedge clk1) begin
    if (!rst) begin
      prog   <= -1;
      m_data <= '0;
      m_key  <= '0;
      m_s1   <= '0;
      m_s2   <= '0;
      m_out  <= '0;
      m_s1d  <= 1'b0;
      m_s2d  <= 1'b0;
    end else if (ld) begin
      m_data <= input_data;
      m_key  <= key_bits;
      m_s1d  <= 1'b0;
      m_s2d  <= 1'b0;
      prog   <= 0;
    end else if (prog == 0) begin
      if (start) prog <= 1;
    end else if (prog == 1) begin
      m_s1  <= rotl(m_data, m_key);
      m_s1d <= 1'b1;
      prog  <= 2;
    end else if (prog == 2) begin
      m_s2  <= addk(m_s1, m_key);
      m_s2d <= 1'b1;
      prog  <= 3;
    end else if (prog == 3) begin
      m_out <= fold(m_s2, m_key);
      prog  <= 4;
    end
  end

  always @(negedge clk1) begin
    if (chk_en) begin
      chk("output_data", 32'(output_data), 32'(m_out));
      chk("stg3_out", 32'(stg3_out), 32'(m_out));
      chk("stg1_out", 32'(stg1_out), 32'(m_s1));
      chk("stg2_out", 32'(stg2_out), 32'(m_s2));
      chk("stg1_done", 32'(stg1_done), 32'(m_s1d));
      chk("stg2_done", 32'(stg2_done), 32'(m_s2d));
`ifdef CRYPTOVERIL_PARITY_EN
      chk("out_parity", 32'(out_parity), 32'(^m_out));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk1);
  endtask

  task automatic run_op(input logic [15:0] d,
                        input logic [4:0] k);
    input_data = d;
    key_bits   = k;
    ld         = 1'b1;
    start      = 1'b1;
    tick(1);
    ld = 1'b0;
    tick(4);
  endtask

  initial begin
    rst        = 1'b0;
    ld         = 1'b0;
    start      = 1'b0;
    input_data = '0;
    key_bits   = '0;
    tick(1);
    chk_en = 1;
    tick(1);
    chk("rst_out", 32'(output_data), 32'h0);
    chk("rst_s2", 32'(stg2_out), 32'h0);
    rst = 1'b1;

    // Start alone in IDLE must not run anything
    start = 1'b1;
    tick(5);
    chk("idle_start", 32'(stg1_done), 32'h0);

    run_op(16'hE1E1, 5'b11010);
    chk("v1_s1", 32'(stg1_out), 32'h8787);
    chk("v1_s2", 32'(stg2_out), 32'h0F2E1);
    chk("v1_out", 32'(output_data), 32'hA88A);
    chk("v1_model", 32'(m_out), 32'hA88A);
`ifdef CRYPTOVERIL_PARITY_EN
    chk("v1_par", 32'(out_parity), 32'h0);
`endif

    run_op(16'hFFFF, 5'h1F);
    chk("v2_s1", 32'(stg1_out), 32'hFFFF);
    chk("v2_s2", 32'(stg2_out), 32'h1FFFE);
    chk("v2_out", 32'(output_data), 32'h0000);

    run_op(16'h1234, 5'h00);
    chk("v3_out", 32'(output_data), 32'h1234);

    // DONE holds with start high
    start = 1'b1;
    tick(20);
    chk("done_hold", 32'(output_data), 32'h1234);

    // Abort in S2 keeps the old result
    input_data = 16'hBEEF;
    key_bits   = 5'h07;
    ld         = 1'b1;
    tick(1);
    ld = 1'b0;
    tick(2);
    ld         = 1'b1;
    start      = 1'b0;
    input_data = 16'h5555;
    tick(1);
    ld = 1'b0;
    tick(5);
    chk("abort_out", 32'(output_data), 32'h1234);
    chk("abort_s2d", 32'(stg2_done), 32'h0);

    // ld and start together hold LOADED
    ld    = 1'b1;
    start = 1'b1;
    tick(3);
    chk("reload_s1d", 32'(stg1_done), 32'h0);
    ld = 1'b0;
    tick(4);
    chk("reload_out", 32'(output_data),
        32'(fold(addk(rotl(16'h5555, 5'h07), 5'h07),
                 5'h07)));

    // Reset during S2
    input_data = 16'hCAFE;
    key_bits   = 5'h0B;
    ld         = 1'b1;
    tick(1);
    ld = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("midrst_out", 32'(output_data), 32'h0);
    chk("midrst_s1", 32'(stg1_out), 32'h0);
    chk("midrst_s1d", 32'(stg1_done), 32'h0);
    rst = 1'b1;
    tick(10);
    chk("post_rst", 32'(output_data), 32'h0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(99) >= 2);
      ld         = ($urandom_range(99) < 12);
      start      = ($urandom_range(99) < 65);
      input_data = 16'($urandom);
      key_bits   = 5'($urandom);
      tick(1);
    end

    rst   = 1'b1;
    ld    = 1'b0;
    start = 1'b0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
